fetch_queue: RTL

//  Instruction fetch unit feeding the decode stage (FD boundary) of the 5-stage core.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// In-order instruction fetch unit: issues word fetches to a variable-latency memory,
// buffers {pc, inst} pairs in a DEPTH-entry FIFO and feeds decode; flushes on REDIRECT.

module fetch_queue_entry #(
  parameter int W = 64
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK) begin
    if (we) q <= d;
  end
endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        STALL,
  output logic        INST_VALID,
  output logic [31:0] INST_PC,
  output logic [31:0] INST
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_ent_t;

  logic          run_q;
  logic [31:0]   fpc, rpc;
  logic [CW-1:0] inflight, kill, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          accept, rsp, push, pop;
  logic [CW-1:0] inflight_nxt;
  logic [CW:0]   budget;

  logic [DEPTH-1:0]          ent_we;
  fq_ent_t [DEPTH-1:0]       ent_q;
  fq_ent_t                   ent_d, head;

  // Killed in-flight requests still occupy a slot, so FIFO overflow cannot happen.
  assign budget       = {1'b0, inflight} + {1'b0, count};
  assign IMEM_REQ     = run_q && (budget < DEPTH_W);
  assign IMEM_ADDR    = fpc;
  assign accept       = IMEM_REQ && IMEM_GNT;
  assign rsp          = IMEM_RVALID && (inflight != '0);
  assign push         = rsp && !REDIRECT && (kill == '0);
  assign pop          = (count != '0) && !STALL && !REDIRECT;
  assign inflight_nxt = inflight + CW'(accept) - CW'(rsp);

  assign ent_d = '{pc: rpc, inst: IMEM_RDATA};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = push && (wr_ptr == AW'(i));
    fetch_queue_entry #(.W($bits(fq_ent_t))) u_ent (
      .CLK (CLK),
      .we  (ent_we[i]),
      .d   (ent_d),
      .q   (ent_q[i])
    );
  end

  assign head       = ent_q[rd_ptr];
  assign INST_VALID = (count != '0);
  assign INST_PC    = INST_VALID ? head.pc   : 32'h0;
  assign INST       = INST_VALID ? head.inst : NOP_INST;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      run_q    <= 1'b0;
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      kill     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run_q    <= 1'b1;
      inflight <= inflight_nxt;
      if (REDIRECT) begin
        // Everything issued before the redirect, including this cycle's accept, is stale.
        fpc    <= REDIRECT_PC;
        rpc    <= REDIRECT_PC;
        kill   <= inflight_nxt;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept) fpc <= fpc + 32'd4;
        if (rsp && (kill != '0)) kill <= kill - CW'(1);
        if (push) begin
          rpc    <= rpc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  a_rvalid_no_inflight: assert property (@(posedge CLK) disable iff (!RESET)
    !(IMEM_RVALID && (inflight == '0)));

endmodule
